// File: rtl/arb_pkg.sv
// Shared types and default widths for the memory-port arbiter.
package arb_pkg;

   typedef enum logic [1:0] {
      IDLE,
      REQ,
      RESP
   } arb_state_t;

   localparam int ARB_ADDR_W = 64;
   localparam int ARB_DATA_W = 64;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first valid index after the last grantee.
module rr_pick #(
   parameter int N_REQ = 2
) (
   input  logic [N_REQ-1:0]         valid,
   input  logic [$clog2(N_REQ)-1:0] last,
   output logic [$clog2(N_REQ)-1:0] winner,
   output logic                     any_valid
);

   localparam int IDX_W = $clog2(N_REQ);

   int idx;

   // NOTE: every output gets a default first so no path through the block can infer a latch.
   always_comb begin
      winner    = '0;
      any_valid = 1'b0;
      idx       = 0;
      // Scan from the farthest candidate inward so the nearest one after last wins.
      for (int k = N_REQ; k >= 1; k--) begin
         idx = int'(last) + k;
         if (idx >= N_REQ) idx = idx - N_REQ;
         if (valid[idx]) begin
            winner    = IDX_W'(idx);
            any_valid = 1'b1;
         end
      end
   end

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one single-beat memory port between N_REQ requesters,
// one transaction at a time, with a sticky watchdog for a stuck memory port.
module mem_arbiter
   import arb_pkg::*;
#(
   parameter int N_REQ   = 2,
   parameter int ADDR_W  = ARB_ADDR_W,
   parameter int DATA_W  = ARB_DATA_W,
   parameter int TIMEOUT = 1024
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic [N_REQ-1:0]           req_valid,
   input  logic [N_REQ-1:0]           req_write,
   input  logic [N_REQ*ADDR_W-1:0]    req_addr,
   input  logic [N_REQ*DATA_W/8-1:0]  req_strobe,
   input  logic [N_REQ*DATA_W-1:0]    req_wdata,
   output logic [N_REQ-1:0]           resp_ok,
   output logic [DATA_W-1:0]          resp_rdata,
   output logic [$clog2(N_REQ)-1:0]   grant_idx,
   output logic                       mem_valid,
   output logic                       mem_write,
   output logic [ADDR_W-1:0]          mem_addr,
   output logic [DATA_W/8-1:0]        mem_strobe,
   output logic [DATA_W-1:0]          mem_wdata,
   input  logic                       mem_ready,
   input  logic [DATA_W-1:0]          mem_rdata,
   output logic                       timeout_err
);

   localparam int IDX_W  = $clog2(N_REQ);
   localparam int STRB_W = DATA_W / 8;
   localparam int CNT_W  = $clog2(TIMEOUT + 1);

   localparam logic [IDX_W-1:0] LAST_RST = IDX_W'(N_REQ - 1);
   localparam logic [CNT_W-1:0] WD_MAX   = CNT_W'(TIMEOUT);
   localparam logic [CNT_W-1:0] WD_LAST  = CNT_W'(TIMEOUT - 1);
   localparam logic [N_REQ-1:0] ONE_HOT0 = N_REQ'(1);

   arb_state_t        state;
   logic [IDX_W-1:0]  last;
   logic [CNT_W-1:0]  wd_cnt;

   logic [IDX_W-1:0]  pick;
   logic              any_valid;
   logic              sel_write;
   logic [ADDR_W-1:0] sel_addr;
   logic [STRB_W-1:0] sel_strobe;
   logic [DATA_W-1:0] sel_wdata;

   rr_pick #(
      .N_REQ (N_REQ)
   ) u_rr_pick (
      .valid     (req_valid),
      .last      (last),
      .winner    (pick),
      .any_valid (any_valid)
   );

   assign sel_write  = req_write[pick];
   assign sel_addr   = req_addr[int'(pick)*ADDR_W +: ADDR_W];
   assign sel_strobe = req_strobe[int'(pick)*STRB_W +: STRB_W];
   assign sel_wdata  = req_wdata[int'(pick)*DATA_W +: DATA_W];

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state       <= IDLE;
         last        <= LAST_RST;
         wd_cnt      <= '0;
         timeout_err <= 1'b0;
         grant_idx   <= '0;
         mem_valid   <= 1'b0;
         mem_write   <= 1'b0;
         mem_addr    <= '0;
         mem_strobe  <= '0;
         mem_wdata   <= '0;
         resp_ok     <= '0;
         resp_rdata  <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (any_valid) begin
                  grant_idx  <= pick;
                  mem_valid  <= 1'b1;
                  mem_write  <= sel_write;
                  mem_addr   <= sel_addr;
                  mem_strobe <= sel_write ? sel_strobe : '0;
                  mem_wdata  <= sel_wdata;
                  wd_cnt     <= '0;
                  state      <= REQ;
               end
            end
            REQ: begin
               if (mem_ready) begin
                  if (!mem_write) resp_rdata <= mem_rdata;
                  last      <= grant_idx;
                  mem_valid <= 1'b0;
                  resp_ok   <= ONE_HOT0 << grant_idx;
                  state     <= RESP;
               end else begin
                  // The transaction is never aborted; the watchdog only reports.
                  if (wd_cnt != WD_MAX) wd_cnt <= wd_cnt + CNT_W'(1);
                  if (wd_cnt == WD_LAST) timeout_err <= 1'b1;
               end
            end
            RESP: begin
               resp_ok <= '0;
               state   <= IDLE;
            end
            default: begin
               resp_ok   <= '0;
               mem_valid <= 1'b0;
               state     <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios plus randomized traffic
// checked against a transaction-level round-robin model.
module tb_mem_arbiter;

   localparam int N_REQ   = 2;
   localparam int ADDR_W  = 64;
   localparam int DATA_W  = 64;
   localparam int STRB_W  = DATA_W / 8;
   localparam int TIMEOUT = 8;
   localparam int IDX_W   = $clog2(N_REQ);

   logic                      clk = 1'b0;
   logic                      reset;
   logic [N_REQ-1:0]          req_valid;
   logic [N_REQ-1:0]          req_write;
   logic [N_REQ*ADDR_W-1:0]   req_addr;
   logic [N_REQ*STRB_W-1:0]   req_strobe;
   logic [N_REQ*DATA_W-1:0]   req_wdata;
   logic [N_REQ-1:0]          resp_ok;
   logic [DATA_W-1:0]         resp_rdata;
   logic [IDX_W-1:0]          grant_idx;
   logic                      mem_valid;
   logic                      mem_write;
   logic [ADDR_W-1:0]         mem_addr;
   logic [STRB_W-1:0]         mem_strobe;
   logic [DATA_W-1:0]         mem_wdata;
   logic                      mem_ready;
   logic [DATA_W-1:0]         mem_rdata;
   logic                      timeout_err;

   logic [ADDR_W-1:0] a_addr  [N_REQ];
   logic [STRB_W-1:0] a_strb  [N_REQ];
   logic [DATA_W-1:0] a_wdata [N_REQ];

   int errors = 0;
   int checks = 0;
   logic [DATA_W-1:0] exp_rdata;

   for (genvar g = 0; g < N_REQ; g++) begin : g_pack
      assign req_addr[g*ADDR_W +: ADDR_W]   = a_addr[g];
      assign req_strobe[g*STRB_W +: STRB_W] = a_strb[g];
      assign req_wdata[g*DATA_W +: DATA_W]  = a_wdata[g];
   end

   mem_arbiter #(
      .N_REQ   (N_REQ),
      .ADDR_W  (ADDR_W),
      .DATA_W  (DATA_W),
      .TIMEOUT (TIMEOUT)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .req_valid   (req_valid),
      .req_write   (req_write),
      .req_addr    (req_addr),
      .req_strobe  (req_strobe),
      .req_wdata   (req_wdata),
      .resp_ok     (resp_ok),
      .resp_rdata  (resp_rdata),
      .grant_idx   (grant_idx),
      .mem_valid   (mem_valid),
      .mem_write   (mem_write),
      .mem_addr    (mem_addr),
      .mem_strobe  (mem_strobe),
      .mem_wdata   (mem_wdata),
      .mem_ready   (mem_ready),
      .mem_rdata   (mem_rdata),
      .timeout_err (timeout_err)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation still running at %0t", $time);
      $fatal(1, "bench time limit expired");
   end

   // Round-robin rule: first requesting index after the last grantee, modulo N_REQ.
   function automatic int rr_winner(logic [N_REQ-1:0] v, int last);
      for (int k = 1; k <= N_REQ; k++) begin
         int idx = (last + k) % N_REQ;
         if (v[idx]) return idx;
      end
      return -1;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      req_valid = '0;
      req_write = '0;
      for (int i = 0; i < N_REQ; i++) begin
         a_addr[i]  = '0;
         a_strb[i]  = '0;
         a_wdata[i] = '0;
      end
      mem_ready = 1'b0;
      mem_rdata = '0;
   endtask

   task automatic do_reset();
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      reset = 1'b1;
      exp_rdata = '0;
   endtask

   task automatic test_reset();
      reset = 1'b0;
      idle_inputs();
      repeat (2) @(posedge clk);
      #1;
      checks++;
      if ({mem_valid, mem_write, resp_ok, timeout_err, grant_idx} !== '0) begin
         errors++;
         $display("FAIL reset_ctrl: got mv=%0b mw=%0b ok=%b err=%0b g=%0d want all 0",
                  mem_valid, mem_write, resp_ok, timeout_err, grant_idx);
      end
      checks++;
      if ({mem_addr, mem_strobe, mem_wdata, resp_rdata} !== '0) begin
         errors++;
         $display("FAIL reset_data: got addr=%h strb=%h wdata=%h rdata=%h want 0",
                  mem_addr, mem_strobe, mem_wdata, resp_rdata);
      end
      @(negedge clk);
      reset = 1'b1;
      exp_rdata = '0;
      tick();
      checks++;
      if (mem_valid !== 1'b0) begin
         errors++;
         $display("FAIL reset_idle: mem_valid=%0b want 0 with no requests", mem_valid);
      end
   endtask

   task automatic test_single_load();
      a_addr[0]    = 64'h8000_0000;
      a_strb[0]    = 8'hFF;
      req_write[0] = 1'b0;
      mem_ready    = 1'b1;
      mem_rdata    = 64'hDEAD_BEEF;
      req_valid    = 2'b01;
      tick();
      checks++;
      if ({mem_valid, mem_write, mem_addr, mem_strobe, grant_idx, resp_ok} !==
          {1'b1, 1'b0, 64'h8000_0000, 8'h00, 1'b0, 2'b00}) begin
         errors++;
         $display("FAIL load_issue: got mv=%0b mw=%0b addr=%h strb=%h g=%0d ok=%b want 1 0 80000000 00 0 00",
                  mem_valid, mem_write, mem_addr, mem_strobe, grant_idx, resp_ok);
      end
      tick();
      checks++;
      if ({mem_valid, resp_ok, resp_rdata} !== {1'b0, 2'b01, 64'hDEAD_BEEF}) begin
         errors++;
         $display("FAIL load_resp: got mv=%0b ok=%b rdata=%h want 0 01 deadbeef",
                  mem_valid, resp_ok, resp_rdata);
      end
      exp_rdata = 64'hDEAD_BEEF;
      req_valid = '0;
      tick();
      checks++;
      if ({mem_valid, resp_ok} !== 3'b000) begin
         errors++;
         $display("FAIL load_after: got mv=%0b ok=%b want 0 00", mem_valid, resp_ok);
      end
   endtask

   task automatic test_contention();
      int n;
      logic [N_REQ-1:0] exp_ok;
      do_reset();
      a_addr[0] = 64'h1000;
      a_addr[1] = 64'h2000;
      req_write = '0;
      mem_ready = 1'b1;
      req_valid = 2'b11;
      for (int t = 0; t < 4; t++) begin
         mem_rdata = 64'hA0 + 64'(t);
         n = 0;
         tick();
         while (mem_valid !== 1'b1 && n < 4) begin
            tick();
            n++;
         end
         checks++;
         if (mem_valid !== 1'b1 || int'(grant_idx) !== (t % 2) || mem_addr !== a_addr[t % 2]) begin
            errors++;
            $display("FAIL contention_grant%0d: got mv=%0b g=%0d addr=%h want 1 %0d %h",
                     t, mem_valid, grant_idx, mem_addr, t % 2, a_addr[t % 2]);
         end
         tick();
         exp_ok = '0;
         exp_ok[t % 2] = 1'b1;
         checks++;
         if (resp_ok !== exp_ok || resp_rdata !== 64'hA0 + 64'(t)) begin
            errors++;
            $display("FAIL contention_resp%0d: got ok=%b rdata=%h want %b %h",
                     t, resp_ok, resp_rdata, exp_ok, 64'hA0 + 64'(t));
         end
      end
      exp_rdata = 64'hA3;
      req_valid = '0;
      tick();
   endtask

   task automatic test_stall();
      req_write[1] = 1'b1;
      a_addr[1]    = 64'h3000;
      a_strb[1]    = 8'hFF;
      a_wdata[1]   = 64'h1234;
      mem_ready    = 1'b0;
      mem_rdata    = 64'hBAD0_BAD0;
      req_valid    = 2'b10;
      tick();
      for (int c = 1; c <= 6; c++) begin
         checks++;
         if ({mem_valid, mem_write, mem_addr, mem_strobe, mem_wdata, grant_idx, resp_ok} !==
             {1'b1, 1'b1, 64'h3000, 8'hFF, 64'h1234, 1'b1, 2'b00}) begin
            errors++;
            $display("FAIL stall_hold%0d: got mv=%0b mw=%0b addr=%h strb=%h wdata=%h g=%0d ok=%b",
                     c, mem_valid, mem_write, mem_addr, mem_strobe, mem_wdata, grant_idx, resp_ok);
         end
         mem_ready = (c == 6);
         tick();
      end
      checks++;
      if ({mem_valid, resp_ok, resp_rdata} !== {1'b0, 2'b10, exp_rdata}) begin
         errors++;
         $display("FAIL stall_resp: got mv=%0b ok=%b rdata=%h want 0 10 %h",
                  mem_valid, resp_ok, resp_rdata, exp_rdata);
      end
      req_valid = '0;
      mem_ready = 1'b0;
      tick();
      checks++;
      if (resp_ok !== 2'b00) begin
         errors++;
         $display("FAIL stall_single_pulse: got ok=%b want 00", resp_ok);
      end
   endtask

   task automatic test_drop();
      int extra;
      req_write[0] = 1'b0;
      a_addr[0]    = 64'h4000;
      mem_ready    = 1'b0;
      req_valid    = 2'b01;
      tick();
      req_valid = '0;
      a_addr[0] = 64'hFFFF;
      tick();
      tick();
      checks++;
      if ({mem_valid, mem_addr} !== {1'b1, 64'h4000}) begin
         errors++;
         $display("FAIL drop_hold: got mv=%0b addr=%h want 1 4000", mem_valid, mem_addr);
      end
      mem_rdata = 64'h5555;
      mem_ready = 1'b1;
      tick();
      checks++;
      if ({resp_ok, resp_rdata} !== {2'b01, 64'h5555}) begin
         errors++;
         $display("FAIL drop_resp: got ok=%b rdata=%h want 01 5555", resp_ok, resp_rdata);
      end
      exp_rdata = 64'h5555;
      extra = 0;
      repeat (3) begin
         tick();
         if (resp_ok !== 2'b00 || mem_valid !== 1'b0) extra++;
      end
      checks++;
      if (extra !== 0) begin
         errors++;
         $display("FAIL drop_quiet: %0d active cycles after completion, want 0", extra);
      end
      mem_ready = 1'b0;
   endtask

   task automatic test_watchdog();
      req_write[0] = 1'b0;
      a_addr[0]    = 64'h6000;
      mem_ready    = 1'b0;
      req_valid    = 2'b01;
      tick();
      checks++;
      if (timeout_err !== 1'b0) begin
         errors++;
         $display("FAIL wd_start: timeout_err=%0b want 0", timeout_err);
      end
      for (int k = 1; k <= 10; k++) begin
         tick();
         checks++;
         if (timeout_err !== (k >= TIMEOUT)) begin
            errors++;
            $display("FAIL wd_stall%0d: timeout_err=%0b want %0b", k, timeout_err, k >= TIMEOUT);
         end
      end
      mem_rdata = 64'h77;
      mem_ready = 1'b1;
      tick();
      checks++;
      if ({resp_ok, resp_rdata, timeout_err} !== {2'b01, 64'h77, 1'b1}) begin
         errors++;
         $display("FAIL wd_complete: got ok=%b rdata=%h err=%0b want 01 77 1",
                  resp_ok, resp_rdata, timeout_err);
      end
      exp_rdata = 64'h77;
      req_valid = '0;
      mem_ready = 1'b0;
      tick();
      checks++;
      if (timeout_err !== 1'b1) begin
         errors++;
         $display("FAIL wd_sticky: timeout_err=%0b want 1", timeout_err);
      end
   endtask

   task automatic test_async_reset();
      int n;
      req_write = '0;
      a_addr[0] = 64'h7000;
      a_addr[1] = 64'h7100;
      mem_ready = 1'b0;
      req_valid = 2'b01;
      tick();
      tick();
      checks++;
      if ({mem_valid, timeout_err} !== 2'b11) begin
         errors++;
         $display("FAIL arst_pre: got mv=%0b err=%0b want 1 1", mem_valid, timeout_err);
      end
      #2;
      reset = 1'b0;
      #1;
      checks++;
      if ({mem_valid, resp_ok, timeout_err} !== 4'b0000) begin
         errors++;
         $display("FAIL arst_immediate: got mv=%0b ok=%b err=%0b want 0 00 0",
                  mem_valid, resp_ok, timeout_err);
      end
      exp_rdata = '0;
      req_valid = 2'b11;
      @(negedge clk);
      reset = 1'b1;
      n = 0;
      tick();
      while (mem_valid !== 1'b1 && n < 4) begin
         tick();
         n++;
      end
      checks++;
      if ({mem_valid, grant_idx, mem_addr} !== {1'b1, 1'b0, 64'h7000}) begin
         errors++;
         $display("FAIL arst_first_grant: got mv=%0b g=%0d addr=%h want 1 0 7000",
                  mem_valid, grant_idx, mem_addr);
      end
      req_valid = '0;
      mem_ready = 1'b1;
      tick();
      checks++;
      if (resp_ok !== 2'b01) begin
         errors++;
         $display("FAIL arst_resp: got ok=%b want 01", resp_ok);
      end
      mem_ready = 1'b0;
      tick();
   endtask

   task automatic new_request(int i);
      req_valid[i] = 1'($urandom_range(0, 1));
      req_write[i] = 1'($urandom_range(0, 1));
      a_addr[i]    = {$urandom, $urandom};
      a_strb[i]    = 8'($urandom);
      a_wdata[i]   = {$urandom, $urandom};
   endtask

   task automatic test_random();
      int exp_last, cur_w, w, stall, max_stall, txns, served;
      logic prev_mv, prev_rsp, prev_ready, exp_mv, exp_rsp;
      logic cur_write;
      logic [ADDR_W-1:0] cur_addr;
      logic [STRB_W-1:0] cur_strb;
      logic [DATA_W-1:0] cur_wdata;
      logic [N_REQ-1:0]  exp_ok;

      idle_inputs();
      do_reset();
      exp_last = N_REQ - 1;
      cur_w = 0; stall = 0; max_stall = 0; txns = 0;
      cur_write = 1'b0; cur_addr = '0; cur_strb = '0; cur_wdata = '0;
      prev_mv = 1'b0; prev_rsp = 1'b0;
      for (int i = 0; i < N_REQ; i++) new_request(i);
      mem_ready  = 1'b1;
      prev_ready = 1'b1;

      for (int cyc = 0; cyc < 400; cyc++) begin
         tick();
         served = -1;
         exp_mv = 1'b0;
         exp_rsp = 1'b0;
         if (prev_mv && prev_ready) begin
            exp_rsp = 1'b1;
            exp_ok = '0;
            exp_ok[cur_w] = 1'b1;
            if (!cur_write) exp_rdata = mem_rdata;
            checks++;
            if ({mem_valid, resp_ok, resp_rdata} !== {1'b0, exp_ok, exp_rdata}) begin
               errors++;
               $display("FAIL rand_resp@%0d: got mv=%0b ok=%b rdata=%h want 0 %b %h",
                        cyc, mem_valid, resp_ok, resp_rdata, exp_ok, exp_rdata);
            end
            exp_last = cur_w;
            served = cur_w;
            txns++;
         end else if (prev_mv) begin
            exp_mv = 1'b1;
            stall++;
            if (stall > max_stall) max_stall = stall;
         end else if (!prev_rsp) begin
            w = rr_winner(req_valid, exp_last);
            if (w >= 0) begin
               exp_mv    = 1'b1;
               cur_w     = w;
               cur_write = req_write[w];
               cur_addr  = a_addr[w];
               cur_strb  = req_write[w] ? a_strb[w] : '0;
               cur_wdata = a_wdata[w];
               stall     = 0;
            end
         end
         if (exp_mv) begin
            checks++;
            if ({mem_valid, mem_write, mem_addr, mem_strobe, mem_wdata, resp_ok} !==
                {1'b1, cur_write, cur_addr, cur_strb, cur_wdata, 2'b00} || int'(grant_idx) !== cur_w) begin
               errors++;
               $display("FAIL rand_req@%0d: got mv=%0b g=%0d mw=%0b addr=%h strb=%h wdata=%h want g=%0d mw=%0b addr=%h strb=%h wdata=%h",
                        cyc, mem_valid, grant_idx, mem_write, mem_addr, mem_strobe, mem_wdata,
                        cur_w, cur_write, cur_addr, cur_strb, cur_wdata);
            end
         end else if (!exp_rsp) begin
            checks++;
            if ({mem_valid, resp_ok} !== 3'b000) begin
               errors++;
               $display("FAIL rand_idle@%0d: got mv=%0b ok=%b want 0 00", cyc, mem_valid, resp_ok);
            end
         end
         prev_mv  = exp_mv;
         prev_rsp = exp_rsp;

         mem_ready = ($urandom_range(0, 2) != 0) || (stall >= 3);
         mem_rdata = {$urandom, $urandom};
         for (int i = 0; i < N_REQ; i++) begin
            if (i == served) begin
               new_request(i);
            end else if (exp_mv && i == cur_w) begin
               // In-flight requester fields are scrambled; the latched copy must win.
               a_addr[i]    = {$urandom, $urandom};
               a_wdata[i]   = {$urandom, $urandom};
               req_valid[i] = 1'($urandom_range(0, 1));
            end else if (!req_valid[i] && $urandom_range(0, 3) == 0) begin
               new_request(i);
            end
         end
         prev_ready = mem_ready;
      end

      checks++;
      if (timeout_err !== (max_stall >= TIMEOUT)) begin
         errors++;
         $display("FAIL rand_watchdog: timeout_err=%0b want %0b (max stall %0d)",
                  timeout_err, max_stall >= TIMEOUT, max_stall);
      end
      checks++;
      if (txns < 20) begin
         errors++;
         $display("FAIL rand_activity: %0d transactions completed, want at least 20", txns);
      end
   endtask

   initial begin
      exp_rdata = '0;
      test_reset();
      test_single_load();
      test_contention();
      test_stall();
      test_drop();
      test_watchdog();
      test_async_reset();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares one single-beat memory port between N_REQ requesters (default: port 0 = instruction fetch, port 1 = data load/store).
- Sits between the pipeline core's fetch/memory stages and the external memory interface.
- Round-robin grant, one outstanding transaction at a time, registered downstream request, one-cycle completion pulse back to the granted requester.
- Watchdog flags a stuck memory port.

Parameters:
N_REQ, 2, number of requesters (>=2)
ADDR_W, 64, address width
DATA_W, 64, data width; strobe width is DATA_W/8
TIMEOUT, 1024, cycles mem_valid may stay unacknowledged before timeout_err sets

Ports:
clk  in  1  clock, all state on rising edge
reset  in  1  asynchronous, active-low reset (0 = in reset)
req_valid  in  N_REQ  per-requester request; held high until its resp_ok bit pulses
req_write  in  N_REQ  1 = store, 0 = load
req_addr  in  N_REQ*ADDR_W  packed addresses, requester i at [i*ADDR_W +: ADDR_W]
req_strobe  in  N_REQ*DATA_W/8  packed byte enables
req_wdata  in  N_REQ*DATA_W  packed store data
resp_ok  out  N_REQ  one-hot, one-cycle completion pulse
resp_rdata  out  DATA_W  load data, valid while resp_ok pulses
grant_idx  out  $clog2(N_REQ)  index of current/last grantee
mem_valid  out  1  downstream request
mem_write  out  1  downstream write
mem_addr  out  ADDR_W  downstream address
mem_strobe  out  DATA_W/8  downstream byte enables, 0 on loads
mem_wdata  out  DATA_W  downstream store data
mem_ready  in  1  downstream accept+complete (single beat)
mem_rdata  in  DATA_W  downstream load data, valid with mem_ready
timeout_err  out  1  sticky watchdog flag

Behaviour:
Reset (reset==0, asynchronous):
- state=IDLE; all outputs 0; round-robin pointer last=N_REQ-1 (requester 0 wins first); watchdog counter 0; timeout_err cleared.

State machine:
- IDLE: if any req_valid, pick the first valid index scanning last+1, last+2, ... mod N_REQ.
  - Register write/addr/strobe/wdata of the winner into mem_* (strobe forced 0 if load).
  - grant_idx<=winner; state<=REQ.
  - If no req_valid, stay in IDLE with mem_valid=0.
- REQ: mem_valid=1; mem_* held constant for the entire state.
  - mem_ready=1: if load, resp_rdata<=mem_rdata (on stores resp_rdata holds its prior value); last<=grant_idx; state<=RESP.
  - mem_ready=0: stay in REQ.
- RESP: exactly one cycle.
  - resp_ok[grant_idx]=1, all other bits 0; mem_valid=0; state<=IDLE.

Latency:
- req_valid sampled in IDLE at edge t; mem_valid high from t+1.
- If mem_ready is high in the first REQ cycle, resp_ok pulses the following cycle.
- Minimum 3 cycles per transaction. No back-to-back issue; IDLE always separates transactions.

Fairness:
- After a grant to i, every other pending requester is served before i again; no starvation.

Requester behaviour during a transaction:
- req_valid dropping or req fields changing in REQ/RESP is ignored; the latched transaction completes and resp_ok still pulses.

Watchdog:
- Counter cleared on entry to REQ; increments each REQ cycle with mem_ready=0; saturates.
- When it reaches TIMEOUT, timeout_err<=1 and stays 1 until reset.
- The transaction keeps waiting; it is never aborted.

Reset mid-transaction:
- Immediate return to reset values; in-flight request dropped; no resp_ok pulse.

Widths:
- Pointer arithmetic is modulo N_REQ, wrapping N_REQ-1 -> 0 (N_REQ need not be a power of two).
- Counter width $clog2(TIMEOUT+1).

Decomposition:
- Shared package arb_pkg: state enum arb_state_t {IDLE, REQ, RESP}; default widths ARB_ADDR_W=64, ARB_DATA_W=64.
- Sub-module rr_pick: combinational round-robin picker. Inputs are the valid vector and last pointer; outputs are winner index and any_valid.

Test Plan:
- Single load: req_valid=01, addr0=0x8000_0000, mem_ready=1 tied, mem_rdata=0xDEAD_BEEF -> mem_valid high 1 cycle with addr 0x8000_0000, strobe 0; resp_ok=01 with resp_rdata=0xDEAD_BEEF 2 cycles after request sampled.
- Contention: req_valid=11 held for 4 transactions -> grants alternate 0,1,0,1; resp_ok sequence 01,10,01,10.
- Stall: store from req 1, strobe 0xFF, wdata 0x1234, mem_ready low 5 cycles -> mem_* stable all 6 REQ cycles, resp_ok=10 once; resp_rdata unchanged.
- Watchdog: TIMEOUT=8, mem_ready held 0 -> timeout_err rises after 8 stalled REQ cycles, remains 1 after a later mem_ready, transaction completes.
- Async reset: assert reset=0 mid-REQ, between clock edges -> mem_valid, resp_ok, timeout_err go 0 immediately; after release with req_valid=11, requester 0 granted first.
- Requester drop: req 0 deasserts valid in REQ -> transaction still completes, resp_ok=01 pulses once.
